// File: rtl/cam_ov7670_emulator.sv
// OV7670 parallel-bus transmitter: QQVGA RGB444 frames on pclk/vsync/href/D.
module cam_ov7670_emulator #(
  parameter int unsigned H_ACTIVE    = 160,
  parameter int unsigned V_ACTIVE    = 120,
  parameter int unsigned H_BLANK     = 16,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BP        = 2,
  parameter int unsigned V_FP        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pattern,
  input  logic [11:0] solid_color,
  output logic        CAM_pclk,
  output logic        CAM_vsync,
  output logic        CAM_href,
  output logic [7:0]  CAM_D,
  output logic        frame_done,
  output logic        busy
);

  localparam int unsigned BPL  = 2 * H_ACTIVE;
  localparam int unsigned LINE = BPL + H_BLANK;
  localparam int unsigned CW   = $clog2((VSYNC_LINES + V_BP + V_FP) * LINE + H_BLANK + 1);
  localparam int unsigned BW   = $clog2(BPL + 1);
  localparam int unsigned XW   = $clog2(H_ACTIVE + 1);
  localparam int unsigned YW   = $clog2(V_ACTIVE + 1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACT, HBL, VFP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   b_q, b_d;
  logic [YW-1:0]   y_q, y_d;
  logic [1:0]      pat_q, pat_d;
  logic [11:0]     solid_q, solid_d;
  logic [7:0]      fcnt_q, fcnt_d;
  logic            pclk_q, vsync_q, href_q, done_q, busy_q;
  logic            vsync_d, href_d, done_d, busy_d;
  logic [7:0]      d_q, d_d;
  logic            start_c;
  logic [XW-1:0]   x_c;
  logic [2:0]      bar_c;
  logic [11:0]     bar_col_c, idx_c, col_c;

  // Frame/line sequencing; everything advances only on the pclk falling edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    y_d     = y_q;
    pat_d   = pat_q;
    solid_d = solid_q;
    fcnt_d  = fcnt_q;
    done_d  = 1'b0;
    start_c = 1'b0;
    if (pclk_q) begin
      case (state_q)
        IDLE: if (en) start_c = 1'b1;
        VSYNC: begin
          if (cnt_q == CW'(VSYNC_LINES * LINE - 1)) begin
            state_d = VBP;
            cnt_d   = '0;
          end else cnt_d = cnt_q + CW'(1);
        end
        VBP: begin
          if (cnt_q == CW'(V_BP * LINE - 1)) begin
            state_d = ACT;
            cnt_d   = '0;
            b_d     = '0;
          end else cnt_d = cnt_q + CW'(1);
        end
        ACT: begin
          if (b_q == BW'(BPL - 1)) begin
            state_d = HBL;
            cnt_d   = '0;
            b_d     = '0;
          end else b_d = b_q + BW'(1);
        end
        HBL: begin
          if (cnt_q == CW'(H_BLANK - 1)) begin
            cnt_d = '0;
            if (y_q == YW'(V_ACTIVE - 1)) state_d = VFP;
            else begin
              y_d     = y_q + YW'(1);
              state_d = ACT;
            end
          end else cnt_d = cnt_q + CW'(1);
        end
        VFP: begin
          if (cnt_q == CW'(V_FP * LINE - 1)) begin
            done_d = 1'b1;
            fcnt_d = fcnt_q + 8'(1);
            cnt_d  = '0;
            if (en) start_c = 1'b1;
            else    state_d = IDLE;
          end else cnt_d = cnt_q + CW'(1);
        end
        default: state_d = IDLE;
      endcase
      if (start_c) begin
        state_d = VSYNC;
        cnt_d   = '0;
        b_d     = '0;
        y_d     = '0;
        pat_d   = pattern;
        solid_d = solid_color;
      end
    end
  end

  // Colour-bar lookup, eight equal bars across the line.
  always_comb begin
    x_c   = XW'(b_d >> 1);
    bar_c = 3'(x_c / XW'(H_ACTIVE / 8));
    case (bar_c)
      3'd0:    bar_col_c = 12'hFFF;
      3'd1:    bar_col_c = 12'hFF0;
      3'd2:    bar_col_c = 12'h0FF;
      3'd3:    bar_col_c = 12'h0F0;
      3'd4:    bar_col_c = 12'hF0F;
      3'd5:    bar_col_c = 12'hF00;
      3'd6:    bar_col_c = 12'h00F;
      default: bar_col_c = 12'h000;
    endcase
  end

  // Pixel colour and output byte derived from the next state so they track the FSM.
  always_comb begin
    idx_c = 12'(32'(y_d) * H_ACTIVE + 32'(x_c));
    case (pat_d)
      2'd0:    col_c = solid_d;
      2'd1:    col_c = bar_col_c;
      2'd2:    col_c = {3{fcnt_d[3:0]}};
      default: col_c = idx_c;
    endcase
    d_d = 8'h00;
    if (state_d == ACT) d_d = b_d[0] ? col_c[7:0] : {4'h0, col_c[11:8]};
    vsync_d = (state_d == VSYNC);
    href_d  = (state_d == ACT);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers; pclk free-runs whenever reset is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      b_q     <= '0;
      y_q     <= '0;
      pat_q   <= '0;
      solid_q <= '0;
      fcnt_q  <= '0;
      pclk_q  <= 1'b0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      d_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      y_q     <= y_d;
      pat_q   <= pat_d;
      solid_q <= solid_d;
      fcnt_q  <= fcnt_d;
      pclk_q  <= ~pclk_q;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      d_q     <= d_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign CAM_pclk   = pclk_q;
  assign CAM_vsync  = vsync_q;
  assign CAM_href   = href_q;
  assign CAM_D      = d_q;
  assign frame_done = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cam_ov7670_emulator.sv
// Bench for cam_ov7670_emulator: full 160-pixel lines, 26 active lines per frame.
module tb_cam_ov7670_emulator;

  localparam int HA    = 160;
  localparam int VA    = 26;
  localparam int HB    = 16;
  localparam int BPL   = 2 * HA;
  localparam int LINE  = BPL + HB;
  localparam int FRAME = (3 + 2 + VA + 2) * LINE;

  logic       clk, rst, en;
  logic [1:0] pattern;
  logic [11:0] solid_color;
  logic       CAM_pclk, CAM_vsync, CAM_href, frame_done, busy;
  logic [7:0] CAM_D;

  cam_ov7670_emulator #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VSYNC_LINES(3), .V_BP(2), .V_FP(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pattern(pattern), .solid_color(solid_color),
    .CAM_pclk(CAM_pclk), .CAM_vsync(CAM_vsync), .CAM_href(CAM_href), .CAM_D(CAM_D),
    .frame_done(frame_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bus monitor: one sample per pclk high phase, taken on the clk falling edge.
  logic [7:0] cap [4][VA][BPL];
  int fr = -1, line = 0, hcount = 0, gap = 0, fcnt = 0, rises = 0;
  int vs_len = 0, pulses = 0, bad_len = 0, bad_gap = 0, first_href = 0;
  int vs_rise_total = 0, href_hi = 0, vs_hi = 0, done_hi = 0;
  int s_vs_len = 0, s_pulses = 0, s_bad_len = 0, s_bad_gap = 0, s_first = 0, s_flen = 0;
  logic pclk_prev = 1'b0, vs_prev = 1'b0, href_prev = 1'b0;

  always @(negedge clk) begin
    if (CAM_pclk === 1'b1 && pclk_prev === 1'b0) begin
      rises++;
      if (CAM_vsync && !vs_prev) begin
        fr++; line = 0; fcnt = 0; vs_len = 0; gap = 0; first_href = 0;
        pulses = 0; bad_len = 0; bad_gap = 0; vs_rise_total++;
      end
      fcnt++;
      if (CAM_vsync) begin vs_len++; vs_hi++; end
      if (CAM_href) begin
        href_hi++;
        if (!href_prev) begin
          hcount = 0; pulses++;
          if (line > 0 && gap != HB) bad_gap++;
          if (line == 0) first_href = fcnt;
        end
        if (fr >= 0 && fr < 4 && line < VA && hcount < BPL) cap[fr][line][hcount] = CAM_D;
        hcount++;
      end else begin
        if (href_prev) begin
          if (hcount != BPL) bad_len++;
          line++; gap = 0;
        end
        gap++;
      end
      vs_prev = CAM_vsync;
      href_prev = CAM_href;
    end
    if (frame_done === 1'b1) begin
      done_hi++;
      s_vs_len = vs_len; s_pulses = pulses; s_bad_len = bad_len;
      s_bad_gap = bad_gap; s_first = first_href; s_flen = fcnt;
    end
    pclk_prev = CAM_pclk;
  end

  typedef struct {
    int fr; int y; int x; logic [7:0] b0; logic [7:0] b1;
  } vec_t;
  vec_t vecs[$];

  int r0, h0, v0, vt;
  logic [7:0] g0, g1;

  initial begin
    // frame 0: pixel index (pattern 3)
    vecs.push_back('{0, 0,   0, 8'h00, 8'h00});
    vecs.push_back('{0, 2,   5, 8'h01, 8'h45});
    vecs.push_back('{0, 0, 159, 8'h00, 8'h9F});
    vecs.push_back('{0, 12, 100, 8'h07, 8'hE4});
    vecs.push_back('{0, 20,  50, 8'h0C, 8'hB2});
    vecs.push_back('{0, 25, 159, 8'h00, 8'h3F});
    // frame 1: colour bars (pattern 1), en/pattern change at y=10 ignored
    vecs.push_back('{1, 0,   0, 8'h0F, 8'hFF});
    vecs.push_back('{1, 0,  20, 8'h0F, 8'hF0});
    vecs.push_back('{1, 0,  39, 8'h0F, 8'hF0});
    vecs.push_back('{1, 0,  40, 8'h00, 8'hFF});
    vecs.push_back('{1, 0,  60, 8'h00, 8'hF0});
    vecs.push_back('{1, 0,  80, 8'h0F, 8'h0F});
    vecs.push_back('{1, 0, 100, 8'h0F, 8'h00});
    vecs.push_back('{1, 0, 120, 8'h00, 8'h0F});
    vecs.push_back('{1, 0, 159, 8'h00, 8'h00});
    vecs.push_back('{1, 25,  0, 8'h0F, 8'hFF});
    vecs.push_back('{1, 25, 100, 8'h0F, 8'h00});
    // frame 2: frame ramp (pattern 2), frame counter = 2
    vecs.push_back('{2, 3,   7, 8'h02, 8'h22});
    vecs.push_back('{2, 9, 150, 8'h02, 8'h22});
    // frame 3: solid 0xABC after mid-line reset
    vecs.push_back('{3, 0,   0, 8'h0A, 8'hBC});
    vecs.push_back('{3, 0, 159, 8'h0A, 8'hBC});

    rst = 1'b1; en = 1'b0; pattern = 2'd0; solid_color = 12'h000;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_pclk", 32'(CAM_pclk), 0);
    check("rst_vsync", 32'(CAM_vsync), 0);
    check("rst_href", 32'(CAM_href), 0);
    check("rst_D", 32'(CAM_D), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_busy", 32'(busy), 0);

    rst = 1'b0;
    r0 = rises; h0 = href_hi; v0 = vs_hi;
    repeat (1000) @(negedge clk);
    check("idle_pclk_rises", 32'(rises - r0 >= 499 && rises - r0 <= 501), 1);
    check("idle_href", 32'(href_hi - h0), 0);
    check("idle_vsync", 32'(vs_hi - v0), 0);
    check("idle_busy", 32'(busy), 0);

    // frame 0: pattern 3, pattern switched to bars mid-frame
    pattern = 2'd3; en = 1'b1;
    for (int i = 0; i < 30000 && !(fr == 0 && line == 5); i++) @(negedge clk);
    check("f0_reach_y5", 32'(fr == 0 && line == 5), 1);
    check("f0_busy", 32'(busy), 1);
    pattern = 2'd1;
    for (int i = 0; i < 30000 && done_hi < 1; i++) @(negedge clk);
    check("f0_done_seen", 32'(done_hi >= 1), 1);
    @(negedge clk);
    check("f0_back_to_back_vsync", 32'(CAM_vsync), 1);
    check("f0_busy_after_done", 32'(busy), 1);
    check("f0_done_once", 32'(done_hi), 1);
    check("f0_vsync_len", 32'(s_vs_len), 32'(3 * LINE));
    check("f0_href_pulses", 32'(s_pulses), 32'(VA));
    check("f0_href_bad_len", 32'(s_bad_len), 0);
    check("f0_href_bad_gap", 32'(s_bad_gap), 0);
    check("f0_first_href", 32'(s_first), 32'(5 * LINE + 1));
    check("f0_frame_len", 32'(s_flen), 32'(FRAME));

    // frame 1: bars; drop en and change pattern at y=10
    for (int i = 0; i < 30000 && !(fr == 1 && line == 10); i++) @(negedge clk);
    check("f1_reach_y10", 32'(fr == 1 && line == 10), 1);
    en = 1'b0; pattern = 2'd0;
    for (int i = 0; i < 30000 && done_hi < 2; i++) @(negedge clk);
    check("f1_done_seen", 32'(done_hi >= 2), 1);
    @(negedge clk);
    check("f1_idle_busy", 32'(busy), 0);
    check("f1_idle_vsync", 32'(CAM_vsync), 0);
    check("f1_href_pulses", 32'(s_pulses), 32'(VA));
    check("f1_frame_len", 32'(s_flen), 32'(FRAME));
    vt = vs_rise_total;
    repeat (1000) @(negedge clk);
    check("f1_no_new_vsync", 32'(vs_rise_total - vt), 0);
    check("f1_still_idle", 32'(busy), 0);
    check("f1_done_total", 32'(done_hi), 2);

    // frame 2: ramp, reset mid-line at y=10, b=77
    pattern = 2'd2; en = 1'b1;
    for (int i = 0; i < 20000 && !(fr == 2 && line == 10 && hcount >= 78); i++) @(negedge clk);
    check("f2_reach_b77", 32'(fr == 2 && line == 10 && hcount >= 78), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_pclk", 32'(CAM_pclk), 0);
    check("mid_rst_vsync", 32'(CAM_vsync), 0);
    check("mid_rst_href", 32'(CAM_href), 0);
    check("mid_rst_D", 32'(CAM_D), 0);
    check("mid_rst_done", 32'(frame_done), 0);
    check("mid_rst_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    pattern = 2'd0; solid_color = 12'hABC;
    rst = 1'b0;
    for (int i = 0; i < 1000 && fr < 3; i++) @(negedge clk);
    check("f3_vsync_start", 32'(fr), 3);
    for (int i = 0; i < 8000 && !(fr == 3 && line >= 1); i++) @(negedge clk);
    check("f3_first_line_done", 32'(fr == 3 && line >= 1), 1);
    check("f3_first_href", 32'(first_href), 32'(5 * LINE + 1));
    check("f3_line_len", 32'(bad_len), 0);

    // captured pixel bytes against the table
    for (int i = 0; i < vecs.size(); i++) begin
      g0 = cap[vecs[i].fr][vecs[i].y][2 * vecs[i].x];
      g1 = cap[vecs[i].fr][vecs[i].y][2 * vecs[i].x + 1];
      check($sformatf("vec%0d_f%0d_y%0d_x%0d_b0", i, vecs[i].fr, vecs[i].y, vecs[i].x),
            32'(g0), 32'(vecs[i].b0));
      check($sformatf("vec%0d_f%0d_y%0d_x%0d_b1", i, vecs[i].fr, vecs[i].y, vecs[i].x),
            32'(g1), 32'(vecs[i].b1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
